// File: rtl/cpu_defs.sv
// Shared widths, address-field positions and fetch-cache FSM encodings.
package cpu_defs;
  localparam int ADDR_W          = 10;
  localparam int NUM_BLOCKS      = 8;
  localparam int IDX_W           = 3;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
  localparam int OFF_W           = 4;
  localparam int TAG_W           = ADDR_W - IDX_W - OFF_W;
  localparam int BADDR_W         = ADDR_W - OFF_W;
  localparam int WSEL_LSB        = 2;
  localparam int IDX_LSB         = OFF_W;
  localparam int TAG_LSB         = OFF_W + IDX_W;
  localparam int MEM_WORDS       = 2 ** (ADDR_W - WSEL_LSB);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } ic_state_e;
endpackage

// File: rtl/instr_mem_model.sv
// 1 KiB block-read instruction memory with a fixed busy latency and a word write port for loading.
module instr_mem_model
  import cpu_defs::*;
#(
  parameter int LATENCY = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-WSEL_LSB-1:0] wr_addr,
  input  logic [WORD_W-1:0]         wr_data,
  input  logic                      read,
  input  logic [BADDR_W-1:0]        address,
  output logic [BLOCK_W-1:0]        readdata,
  output logic                      busywait
);
  localparam logic [7:0] LAST = 8'(LATENCY - 1);

  logic [WORD_W-1:0] mem [0:MEM_WORDS-1];
  logic [7:0]        cnt_q;

  // Busy for LATENCY-1 cycles of a request; data presented in the cycle busy drops.
  assign busywait = read && (cnt_q != LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt_q <= '0;
    else if (!read || !busywait) cnt_q <= '0;
    else                        cnt_q <= cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  for (genvar w = 0; w < WORDS_PER_BLOCK; w++) begin : g_word
    assign readdata[w*WORD_W +: WORD_W] = mem[{address, 2'(w)}];
  end
endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, stalling block fill on miss.
module instr_cache
  import cpu_defs::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        PC,
  output logic [WORD_W-1:0]  INSTRUCTION,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic [BADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);
  logic [TAG_W-1:0]   pc_tag;
  logic [IDX_W-1:0]   pc_idx;
  logic [1:0]         pc_wsel;
  logic [BADDR_W-1:0] pc_baddr;
  logic               pc_unused;

  assign pc_tag    = PC[ADDR_W-1:TAG_LSB];
  assign pc_idx    = PC[TAG_LSB-1:IDX_LSB];
  assign pc_wsel   = PC[IDX_LSB-1:WSEL_LSB];
  assign pc_baddr  = PC[ADDR_W-1:OFF_W];
  assign pc_unused = ^{PC[31:ADDR_W], PC[WSEL_LSB-1:0]};

  logic [NUM_BLOCKS-1:0]                         valid_q;
  logic [NUM_BLOCKS-1:0][TAG_W-1:0]              tag_q;
  logic [NUM_BLOCKS-1:0][BLOCK_W-1:0]            data_q;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0]        line_w;
  logic [BADDR_W-1:0]                            fill_addr_q;
  logic [IDX_W-1:0]                              fill_idx;
  logic [TAG_W-1:0]                              fill_tag;
  ic_state_e                                     state_q, state_d;
  logic                                          hit, busy, fill_en;

  assign hit         = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign line_w      = data_q[pc_idx];
  assign INSTRUCTION = line_w[pc_wsel];
  assign fill_idx    = fill_addr_q[IDX_W-1:0];
  assign fill_tag    = fill_addr_q[BADDR_W-1:IDX_W];

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    MEM_READ = 1'b0;
    fill_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = !hit;
        if (!hit) state_d = S_MEM_READ;
      end
      S_MEM_READ: begin
        MEM_READ = 1'b1;
        busy     = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill_en = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is released while reset is held even though nothing is valid yet.
  assign BUSYWAIT    = busy && !RESET;
  assign MEM_ADDRESS = (state_q == S_MEM_READ) ? fill_addr_q : pc_baddr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Fill target is frozen once the miss leaves IDLE, so a PC change mid-fill cannot redirect it.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE) fill_addr_q <= pc_baddr;
    if (fill_en) begin
      data_q[fill_idx] <= MEM_READDATA;
      tag_q[fill_idx]  <= fill_tag;
    end
  end
endmodule
